aes256_key_sched_ctrl: RTL and testbench

Sequential AES-256 key-schedule controller. Accepts a 256-bit cipher key over a valid/ready handshake and generates the 15 round keys iteratively, one 128-bit round key per clock, into an internal round-key register file. Then serves indexed round-key reads to the AES round datapath. Replaces whole-schedule combinational expansion with a 13-cycle sequenced one that reuses a single S-box stage.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes256_ks_step.sv | 29 ++
 rtl/aes256_key_sched_ctrl.sv | 120 ++++++++++++
 tb/tb_aes256_key_sched_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round/key sizes, GF(2^8) helpers, S-box, controller states.
package aes_pkg;

    localparam int unsigned NR = 14;
    localparam int unsigned NK = 8;

    typedef logic [127:0] rk_t;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_READY
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] b;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes256_ks_step.sv
// One AES-256 key-expansion step: previous eight words -> next 128-bit round key.
module aes256_ks_step
    import aes_pkg::*;
(
    input  logic [32*NK-1:0] win_i,
    input  logic             odd_i,
    input  logic [7:0]       rcon_i,
    output rk_t              rk_o
);

    logic [31:0] last;
    logic [31:0] sin;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    // RotWord is applied before the shared S-box row so only four lookups exist.
    always_comb begin
        last = win_i[31:0];
        sin  = odd_i ? last : {last[23:0], last[31:24]};
        t    = {sbox(sin[31:24]), sbox(sin[23:16]), sbox(sin[15:8]), sbox(sin[7:0])};
        if (!odd_i) t = t ^ {rcon_i, 24'h0};
        n0   = win_i[255:224] ^ t;
        n1   = win_i[223:192] ^ n0;
        n2   = win_i[191:160] ^ n1;
        n3   = win_i[159:128] ^ n2;
        rk_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 sequenced key-schedule controller with indexed round-key read port.
// Optional AES_KS_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes256_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         ks_busy,
    output logic         ks_done,
    output logic         ks_valid,
`ifdef AES_KS_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         rd_valid,
    output logic         rd_err
);

    ks_state_e    state_q;
    rk_t          rk_q [0:NR];
    logic [255:0] win_q;
    logic [3:0]   r_q;
    logic [7:0]   rcon_q;
    logic         ready_q, busy_q, done_q, valid_q;
    logic [127:0] rd_data_q;
    logic         rd_valid_q, rd_err_q;
    rk_t          rk_d;

    aes256_ks_step u_step (
        .win_i  (win_q),
        .odd_i  (r_q[0]),
        .rcon_i (rcon_q),
        .rk_o   (rk_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= KS_IDLE;
            for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
            win_q      <= '0;
            r_q        <= '0;
            rcon_q     <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= rd_en;
            rd_err_q   <= 1'b0;
            // Reads see pre-transfer ks_valid, so a same-cycle key load still serves the old schedule.
            if (rd_en) begin
                if (valid_q && rd_idx <= 4'(NR)) begin
                    rd_data_q <= rk_q[rd_idx];
                end else begin
                    rd_data_q <= '0;
                    rd_err_q  <= 1'b1;
                end
            end
            case (state_q)
                KS_EXPAND: begin
                    rk_q[r_q] <= rk_d;
                    win_q     <= {win_q[127:0], rk_d};
                    r_q       <= r_q + 4'd1;
                    if (!r_q[0]) rcon_q <= xtime(rcon_q);
                    if (r_q == 4'(NR)) begin
                        state_q <= KS_READY;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (key_valid) begin
                        rk_q[0] <= key_in[255:128];
                        rk_q[1] <= key_in[127:0];
                        win_q   <= key_in;
                        r_q     <= 4'd2;
                        rcon_q  <= 8'h01;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= KS_EXPAND;
                    end
                end
            endcase
`ifdef AES_KS_ZEROIZE_EN
            if (zeroize) begin
                for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
                win_q     <= '0;
                rd_data_q <= '0;
                rd_err_q  <= rd_en;
                valid_q   <= 1'b0;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
                ready_q   <= 1'b1;
                state_q   <= KS_IDLE;
            end
`endif
        end
    end

    assign key_ready = ready_q;
    assign ks_busy   = busy_q;
    assign ks_done   = done_q;
    assign ks_valid  = valid_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Self-checking bench for aes256_key_sched_ctrl against a FIPS-197 style word-loop key expansion.
module tb_aes256_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready, ks_busy, ks_done, ks_valid;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_data;
    logic         rd_valid, rd_err;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [15];
    logic [127:0] old_rk [15];

    aes256_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .ks_busy   (ks_busy),
        .ks_done   (ks_done),
        .ks_valid  (ks_valid),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box table built by brute-force inverse search plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key(input logic [255:0] k, input logic hold_other, input logic [255:0] other);
        int n;
        key_in    = k;
        key_valid = 1'b1;
        tick();
        check_val("busy_after_xfer", 128'(ks_busy), 128'(1));
        if (hold_other) key_in = other;
        else key_valid = 1'b0;
        n = 0;
        while (!ks_done && n < 40) begin
            tick();
            n++;
            if (n == 6) begin
                check_val("ready_mid_expand", 128'(key_ready), 128'(0));
                check_val("busy_mid_expand", 128'(ks_busy), 128'(1));
            end
        end
        key_valid = 1'b0;
        check_val("done_latency", 128'(n), 128'(13));
        check_val("valid_at_done", 128'(ks_valid), 128'(1));
        check_val("ready_at_done", 128'(key_ready), 128'(1));
        check_val("busy_at_done", 128'(ks_busy), 128'(0));
        model_expand(k);
    endtask

    task automatic read_one(input string tag, input int idx, input logic exp_err, input logic [127:0] exp_data);
        rd_idx = 4'(idx);
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
        check_val({tag, "_valid"}, 128'(rd_valid), 128'(1));
        check_val({tag, "_err"}, 128'(rd_err), 128'(exp_err));
        check_val({tag, "_data"}, rd_data, exp_data);
    endtask

    // Back-to-back reads of every index including the out-of-range one.
    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            rd_en  = 1'b1;
            tick();
            check_val("rdall_valid", 128'(rd_valid), 128'(1));
            if (i < 15) begin
                check_val("rdall_err", 128'(rd_err), 128'(0));
                check_val($sformatf("rdall_rk%0d", i), rd_data, exp_rk[i]);
            end else begin
                check_val("rdall_idx15_err", 128'(rd_err), 128'(1));
                check_val("rdall_idx15_data", rd_data, 128'(0));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_key_ready"}, 128'(key_ready), 128'(1));
        check_val({tag, "_busy"}, 128'(ks_busy), 128'(0));
        check_val({tag, "_done"}, 128'(ks_done), 128'(0));
        check_val({tag, "_ks_valid"}, 128'(ks_valid), 128'(0));
        check_val({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
        check_val({tag, "_rd_err"}, 128'(rd_err), 128'(0));
        check_val({tag, "_rd_data"}, rd_data, 128'(0));
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    initial begin
        logic [255:0] key_a, key_b;
        int n;
        build_sbox();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        read_one("rd_before_key", 0, 1'b1, 128'(0));

        key_a = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        load_key(key_a, 1'b1, rand_key());
        read_one("kat_rk0", 0, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
        read_one("kat_rk1", 1, 1'b0, 128'h101112131415161718191a1b1c1d1e1f);
        read_one("kat_rk2", 2, 1'b0, 128'ha573c29fa176c498a97fce93a572c09c);
        read_one("kat_rk14", 14, 1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_all();

        for (int i = 0; i < 15; i++) old_rk[i] = exp_rk[i];
        key_b     = rand_key();
        key_in    = key_b;
        key_valid = 1'b1;
        rd_idx    = 4'd14;
        rd_en     = 1'b1;
        tick();
        key_valid = 1'b0;
        check_val("xfer_read_err", 128'(rd_err), 128'(0));
        check_val("xfer_read_old_rk14", rd_data, old_rk[14]);
        rd_idx = 4'd5;
        n = 0;
        while (!ks_done && n < 40) begin
            tick();
            n++;
            check_val("read_during_expand_err", 128'(rd_err), 128'(1));
        end
        check_val("reload_done_latency", 128'(n), 128'(13));
        model_expand(key_b);
        tick();
        rd_en = 1'b0;
        check_val("reload_rk5_err", 128'(rd_err), 128'(0));
        check_val("reload_rk5", rd_data, exp_rk[5]);
        read_all();

        for (int t = 0; t < 4; t++) begin
            load_key(rand_key(), 1'(t % 2), rand_key());
            read_all();
        end

        key_in    = rand_key();
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #2;
        rst_n = 1'b1;
        tick();
        read_one("rd_after_midreset", 3, 1'b1, 128'(0));
        load_key(rand_key(), 1'b0, '0);
        read_all();

`ifdef AES_KS_ZEROIZE_EN
        zeroize   = 1'b1;
        key_in    = rand_key();
        key_valid = 1'b1;
        rd_idx    = 4'd3;
        rd_en     = 1'b1;
        tick();
        zeroize   = 1'b0;
        key_valid = 1'b0;
        rd_en     = 1'b0;
        check_val("zero_rd_err", 128'(rd_err), 128'(1));
        check_val("zero_rd_data", rd_data, 128'(0));
        check_val("zero_ks_valid", 128'(ks_valid), 128'(0));
        check_val("zero_no_xfer_busy", 128'(ks_busy), 128'(0));
        check_val("zero_key_ready", 128'(key_ready), 128'(1));
        read_one("rd_after_zero", 3, 1'b1, 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
